// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: debouncer FSM states and default timing for a 100 MHz sysclk.
package board_io_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

  localparam int unsigned N_BTN_DEFAULT           = 5;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;    // 5 ms
  localparam int unsigned REPEAT_DELAY_DEFAULT    = 50000000;  // 500 ms
  localparam int unsigned REPEAT_PERIOD_DEFAULT   = 10000000;  // 100 ms

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter, level FSM and,
// when AUTO_REPEAT_EN is defined, a hold-to-repeat press generator.
module debounce_channel
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
`endif
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          s;

  assign s = sync_q[1];

  always_comb begin
    sync_d = {sync_q[0], btn_raw};
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_NEXT  = RW'(REPEAT_PERIOD);

  logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc;
  logic          rep_q, rep_d;
  logic          rep_fire;

  // Repeat timing only advances while the accepted level is high and still held;
  // every other state (including a bounce back into IDLE_HIGH) restarts the delay.
  always_comb begin
    rcnt_d   = '0;
    rep_d    = 1'b0;
    rcnt_inc = rcnt_q + RW'(1);
    rep_fire = 1'b0;
    if (state_q == IDLE_HIGH && s) begin
      if ((!rep_q && rcnt_inc == R_FIRST) || (rep_q && rcnt_inc == R_NEXT)) begin
        rep_fire = 1'b1;
        rep_d    = 1'b1;
        rcnt_d   = '0;
      end else begin
        rep_d  = rep_q;
        rcnt_d = rcnt_inc;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rep_q  <= rep_d;
    end
  end
`else
  logic rep_fire;
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = rep_fire;
    release_d = 1'b0;
    cnt_inc   = cnt_q + CW'(1);
    unique case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
        end else if (cnt_inc == CNT_LAST) begin
          state_d = IDLE_HIGH;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
        end else if (cnt_inc == CNT_LAST) begin
          state_d   = IDLE_LOW;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/button_debouncer.sv
// N independent push-button debounce channels producing clean levels and press/release pulses.
// Optional auto-repeat of btn_press while held: define AUTO_REPEAT_EN.
module button_debouncer
  import board_io_pkg::*;
#(
  parameter int unsigned N_BTN           = N_BTN_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // Elaboration guard against timing values the channel counters cannot honour.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2 and repeat timings non-zero");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .sysclk      (sysclk),
      .reset_n     (reset_n),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed cycle-exact scenarios plus
// randomized bounce traffic compared every cycle against a behavioural model.
module tb_button_debouncer;

  localparam int unsigned NB = 2;
  localparam int unsigned DC = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;
`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          sysclk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  int checks = 0;
  int errors = 0;

  button_debouncer #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .sysclk      (sysclk),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 sysclk = ~sysclk;

  // Behavioural model: an input is accepted once the synchronised value has
  // differed from the accepted level for DC consecutive observed cycles, the
  // observed value lagging the pad by three edges (two sync stages + decision).
  bit            m_d1 [NB];
  bit            m_d2 [NB];
  bit            m_lvl[NB];
  int            m_run [NB];
  int            m_hold[NB];
  logic [NB-1:0] m_level = '0, m_press = '0, m_release = '0;

  always @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NB; c++) begin
        m_d1[c] = 1'b0; m_d2[c] = 1'b0; m_lvl[c] = 1'b0;
        m_run[c] = 0;   m_hold[c] = 0;
      end
      m_level = '0; m_press = '0; m_release = '0;
    end else begin
      for (int c = 0; c < NB; c++) begin
        bit s;
        s = m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = btn_raw[c];
        m_press[c] = 1'b0;
        m_release[c] = 1'b0;
        if (s != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == int'(DC)) begin
            m_lvl[c] = s;
            m_run[c] = 0;
            m_hold[c] = 0;
            if (s) m_press[c] = 1'b1;
            else   m_release[c] = 1'b1;
          end
        end else if (m_run[c] != 0) begin
          m_run[c] = 0;
          m_hold[c] = 0;
        end else if (m_lvl[c]) begin
          m_hold[c]++;
          if (REP_EN && (m_hold[c] == int'(RD) ||
              (m_hold[c] > int'(RD) && (m_hold[c] - int'(RD)) % int'(RP) == 0)))
            m_press[c] = 1'b1;
        end
        m_level[c] = m_lvl[c];
      end
    end
  end

  always @(negedge sysclk) begin
    checks++;
    if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
      errors++;
      $display("FAIL model_cmp t=%0t level/press/release actual=%b/%b/%b required=%b/%b/%b",
               $time, btn_level, btn_press, btn_release, m_level, m_press, m_release);
    end
    checks++;
    if ((btn_press & btn_release) !== '0) begin
      errors++;
      $display("FAIL press_release_excl t=%0t actual=%b required=00", $time, btn_press & btn_release);
    end
  end

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  // Advance k clock edges and land 1 time unit after the last one.
  task automatic adv(input int k);
    repeat (k) @(posedge sysclk);
    #1;
  endtask

  initial begin
    int presses;
    logic [NB-1:0] e_press, e_rel;

    // 1: reset with both inputs held, then release
    btn_raw = 2'b11;
    adv(3);
    chk("rst_level", btn_level, 2'b00);
    chk("rst_press", btn_press, 2'b00);
    chk("rst_release", btn_release, 2'b00);
    reset_n = 1'b1;
    adv(5);
    chk("rel_c5_press", btn_press, 2'b00);
    chk("rel_c5_level", btn_level, 2'b00);
    adv(1);
    chk("rel_c6_press", btn_press, 2'b11);
    chk("rel_c6_level", btn_level, 2'b11);
    chk("rel_c6_model", m_press, 2'b11);
    adv(1);
    chk("rel_c7_press", btn_press, 2'b00);
    btn_raw = 2'b00;
    adv(6);
    chk("both_release", btn_release, 2'b11);
    chk("both_level0", btn_level, 2'b00);
    adv(4);

    // 2: clean press and release on ch0
    btn_raw = 2'b01;
    adv(5);
    chk("clean_c5", btn_press, 2'b00);
    adv(1);
    chk("clean_c6_press", btn_press, 2'b01);
    chk("clean_c6_level", btn_level, 2'b01);
    chk("clean_c6_model", m_level, 2'b01);
    adv(1);
    chk("clean_c7_press", btn_press, 2'b00);
    adv(13);
    btn_raw = 2'b00;
    adv(5);
    chk("clean_rel_c25", btn_release, 2'b00);
    adv(1);
    chk("clean_rel_c26", btn_release, 2'b01);
    chk("clean_rel_lvl", btn_level, 2'b00);
    adv(1);
    chk("clean_rel_c27", btn_release, 2'b00);
    adv(4);

    // 3: bounce 1,0,1,1,0,1 then steady high
    presses = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < 6) btn_raw = (k == 1 || k == 4) ? 2'b00 : 2'b01;
      adv(1);
      if (btn_press[0]) presses++;
      chk("bounce_press", btn_press, (k + 1 == 11) ? 2'b01 : 2'b00);
    end
    checks++;
    if (presses != 1) begin
      errors++;
      $display("FAIL bounce_count actual=%0d required=1", presses);
    end
    btn_raw = 2'b00;
    adv(10);

    // 4: 3-cycle glitch on ch1 is rejected
    btn_raw = 2'b10;
    adv(3);
    btn_raw = 2'b00;
    for (int k = 0; k < 10; k++) begin
      chk("glitch_level", btn_level, 2'b00);
      chk("glitch_pulse", btn_press | btn_release, 2'b00);
      adv(1);
    end

    // 5: reset mid-debounce discards progress and clears accepted levels
    btn_raw = 2'b10;
    adv(7);
    chk("pre_rst_level", btn_level, 2'b10);
    btn_raw = 2'b11;
    adv(5);
    reset_n = 1'b0;
    #1;
    chk("midrst_level", btn_level, 2'b00);
    chk("midrst_press", btn_press, 2'b00);
    adv(2);
    reset_n = 1'b1;
    adv(5);
    chk("midrst_c5", btn_press, 2'b00);
    adv(1);
    chk("midrst_c6", btn_press, 2'b11);
    chk("midrst_c6_lvl", btn_level, 2'b11);
    btn_raw = 2'b00;
    adv(12);

    // 6: long hold on ch0 (auto-repeat when enabled), released at k=23
    btn_raw = 2'b01;
    for (int k = 1; k <= 32; k++) begin
      adv(1);
      e_press = (k == 6 || (REP_EN && (k == 16 || k == 19 || k == 22 || k == 25))) ? 2'b01 : 2'b00;
      e_rel   = (k == 29) ? 2'b01 : 2'b00;
      chk("hold_press", btn_press, e_press);
      chk("hold_release", btn_release, e_rel);
      if (k == 16) chk("hold_model_rep", m_press, e_press);
      if (k == 23) btn_raw = 2'b00;
    end
    adv(4);

    // Random bounce traffic with calm/noisy phases and rare resets
    for (int blk = 0; blk < 80; blk++) begin
      int unsigned rate;
      rate = ($urandom_range(0, 2) == 0) ? 3 : 60;
      for (int k = 0; k < 50; k++) begin
        for (int c = 0; c < NB; c++)
          if ($urandom_range(0, rate - 1) == 0) btn_raw[c] = ~btn_raw[c];
        if ($urandom_range(0, 1499) == 0) begin
          reset_n = 1'b0;
          adv(1);
          reset_n = 1'b1;
        end
        adv(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
